// File: rtl/qerv_ldst_shift_buf.sv
// qerv load/store/shift buffer: serial 32-bit operand fill, then store
// presentation, load capture and lane drain, or a saturating shift counter.
module qerv_ldst_shift_buf #(
    parameter int unsigned W  = 1,
    parameter int unsigned LB = $clog2(W)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic          i_init,
    input  logic          i_cnt_done,
    input  logic [1:0]    i_mode,
    input  logic [1:0]    i_size,
    input  logic          i_signed,
    input  logic [1:0]    i_lsb,
    input  logic          i_right,
    input  logic          i_op_b_sel,
    input  logic [W-1:0]  i_rs2,
    input  logic [W-1:0]  i_imm,
    input  logic          i_ack,
    input  logic [31:0]   i_dat,
    output logic [W-1:0]  o_op_b,
    output logic [W-1:0]  o_q,
    output logic [31:0]   o_dat,
    output logic [3:0]    o_sel,
    output logic          o_sh_done,
    output logic          o_sh_done_r,
    output logic [LB:0]   o_sh_rem,
    output logic          o_busy
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 6;
    localparam int unsigned RW = LB + 1;

    // Reject slice widths the serial datapath cannot support
    if (!(W == 1 || W == 2 || W == 4 || W == 8)) begin : g_bad_w
        $error("qerv_ldst_shift_buf: W must be 1, 2, 4 or 8");
    end
    if (LB != $clog2(W)) begin : g_bad_lb
        $error("qerv_ldst_shift_buf: LB is derived from W and must not be overridden");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_STWAIT,
        S_LDWAIT,
        S_DRAIN,
        S_ALIGN,
        S_COUNT
    } state_t;

    state_t          state_q, state_n;
    logic [DW-1:0]   data_q, data_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic [CW-1:0]   ctr_q, ctr_n;
    logic [1:0]      mode_q, mode_n;
    logic [1:0]      size_q, size_n;
    logic [1:0]      lsb_q, lsb_n;
    logic            sign_q, sign_n;
    logic            right_q, right_n;

    logic [DW-1:0]   fill_val;
    logic [RW-1:0]   fill_rem;
    logic [RW-1:0]   rem_n;
    logic [CW-1:0]   ctr_dec;
    logic            start;
    logic [5:0]      lane_sz;

    logic [DW-1:0]   dat_n;
    logic [3:0]      sel_n;
    logic [W-1:0]    q_n;
    logic            busy_n;
    logic            shdr_n;
    logic [RW-1:0]   sh_rem_n;

    assign o_op_b   = i_op_b_sel ? i_rs2 : i_imm;
    assign fill_val = {o_op_b, data_q[DW-1:W]};
    assign ctr_dec  = ctr_q - CW'(W);
    assign start    = (state_q == S_IDLE) && i_init && i_en && (i_mode != 2'b00);
    assign lane_sz  = (size_n == 2'b00) ? 6'd8 : (size_n == 2'b01) ? 6'd16 : 6'd32;

    assign o_sh_done = (state_q == S_COUNT) && i_en && ctr_dec[CW-1];

    // Shift remainder (shamt mod W) of the freshly filled and the next buffer
    if (W > 1) begin : g_rem
        assign fill_rem = RW'(fill_val[LB-1:0]);
        assign rem_n    = RW'(data_n[LB-1:0]);
    end else begin : g_no_rem
        assign fill_rem = '0;
        assign rem_n    = '0;
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state sequencing
    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_n = S_FILL;
            end
            S_FILL: begin
                if (i_en && i_cnt_done) begin
                    case (mode_q)
                        2'b01:   state_n = S_STWAIT;
                        2'b10:   state_n = S_LDWAIT;
                        2'b11:   state_n = (right_q && (fill_rem != '0)) ? S_ALIGN : S_COUNT;
                        default: state_n = S_IDLE;
                    endcase
                end
            end
            S_STWAIT: begin
                if (i_ack) state_n = S_IDLE;
            end
            S_LDWAIT: begin
                if (i_ack) state_n = S_DRAIN;
            end
            S_DRAIN: begin
                if (i_en && i_cnt_done) state_n = S_IDLE;
            end
            S_ALIGN: begin
                if (i_en) state_n = S_COUNT;
            end
            S_COUNT: begin
                if (i_en && i_cnt_done) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Buffer, drain counter, shift counter and latched operation attributes
    always_comb begin
        data_n  = data_q;
        cnt_n   = cnt_q;
        ctr_n   = ctr_q;
        mode_n  = mode_q;
        size_n  = size_q;
        lsb_n   = lsb_q;
        sign_n  = sign_q;
        right_n = right_q;
        if (start) begin
            mode_n  = i_mode;
            size_n  = i_size;
            lsb_n   = i_lsb;
            sign_n  = i_signed;
            right_n = i_right;
            data_n  = fill_val;
        end
        if ((state_q == S_FILL) && i_en) begin
            data_n = fill_val;
            if (i_cnt_done && (mode_q == 2'b11)) ctr_n = {1'b0, fill_val[4:0]};
        end
        if ((state_q == S_LDWAIT) && i_ack) begin
            data_n = i_dat;
            cnt_n  = '0;
        end
        if ((state_q == S_DRAIN) && i_en) cnt_n = cnt_q + CW'(W);
        if ((state_q == S_COUNT) && i_en && !ctr_q[CW-1]) ctr_n = ctr_dec;
    end

    // Next values of the registered outputs, decoded from the next state
    always_comb begin
        dat_n    = '0;
        sel_n    = '0;
        q_n      = '0;
        sh_rem_n = '0;
        busy_n   = (state_n != S_IDLE);
        shdr_n   = (state_n == S_COUNT) && ctr_n[CW-1];
        if (state_n == S_STWAIT) begin
            case (size_n)
                2'b00:   dat_n = {4{data_n[7:0]}};
                2'b01:   dat_n = {2{data_n[15:0]}};
                default: dat_n = data_n;
            endcase
        end
        if ((state_n == S_STWAIT) || (state_n == S_LDWAIT)) begin
            case (size_n)
                2'b00:   sel_n = 4'b0001 << lsb_n;
                2'b01:   sel_n = lsb_n[1] ? 4'b1100 : 4'b0011;
                default: sel_n = 4'b1111;
            endcase
        end
        if ((state_n == S_ALIGN) || (state_n == S_COUNT)) sh_rem_n = rem_n;
        if (state_n == S_DRAIN) begin
            for (int k = 0; k < int'(W); k++) begin
                if (int'(cnt_n) + k < int'(lane_sz)) begin
                    q_n[k] = data_n[5'(8 * int'(lsb_n) + int'(cnt_n) + k)];
                end else begin
                    q_n[k] = sign_n & data_n[5'(8 * int'(lsb_n) + int'(lane_sz) - 1)];
                end
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q      <= '0;
            cnt_q       <= '0;
            ctr_q       <= '0;
            mode_q      <= '0;
            size_q      <= '0;
            lsb_q       <= '0;
            sign_q      <= 1'b0;
            right_q     <= 1'b0;
            o_dat       <= '0;
            o_sel       <= '0;
            o_q         <= '0;
            o_busy      <= 1'b0;
            o_sh_done_r <= 1'b0;
            o_sh_rem    <= '0;
        end else begin
            data_q      <= data_n;
            cnt_q       <= cnt_n;
            ctr_q       <= ctr_n;
            mode_q      <= mode_n;
            size_q      <= size_n;
            lsb_q       <= lsb_n;
            sign_q      <= sign_n;
            right_q     <= right_n;
            o_dat       <= dat_n;
            o_sel       <= sel_n;
            o_q         <= q_n;
            o_busy      <= busy_n;
            o_sh_done_r <= shdr_n;
            o_sh_rem    <= sh_rem_n;
        end
    end

endmodule

// File: tb/tb_qerv_ldst_shift_buf.sv
// Bench for qerv_ldst_shift_buf: one instance per legal W (1,2,4,8), driven
// one at a time through store, load and shift operations against a
// lane/rotation reference model.
module tb_qerv_ldst_shift_buf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  en;
    logic        init, cnt_done, sgn, right, op_b_sel, ack;
    logic [1:0]  mode, size, lsb;
    logic [7:0]  rs2, imm;
    logic [31:0] dat;

    logic [3:0][7:0]  opb_o, q_o;
    logic [3:0][31:0] dat_o;
    logic [3:0][3:0]  sel_o, rem_o;
    logic [3:0]       shd_o, shdr_o, busy_o;

    int ntests = 0;
    int nfail  = 0;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        localparam int unsigned WW = 1 << gi;
        localparam int unsigned LL = gi;
        logic [WW-1:0] opb, q;
        logic [LL:0]   rem;
        logic [31:0]   d;
        logic [3:0]    s;
        logic          shd, shdr, busy;

        qerv_ldst_shift_buf #(.W(WW)) u_dut (
            .i_clk       (clk),
            .i_rst_n     (rst_n),
            .i_en        (en[gi]),
            .i_init      (init),
            .i_cnt_done  (cnt_done),
            .i_mode      (mode),
            .i_size      (size),
            .i_signed    (sgn),
            .i_lsb       (lsb),
            .i_right     (right),
            .i_op_b_sel  (op_b_sel),
            .i_rs2       (rs2[WW-1:0]),
            .i_imm       (imm[WW-1:0]),
            .i_ack       (ack),
            .i_dat       (dat),
            .o_op_b      (opb),
            .o_q         (q),
            .o_dat       (d),
            .o_sel       (s),
            .o_sh_done   (shd),
            .o_sh_done_r (shdr),
            .o_sh_rem    (rem),
            .o_busy      (busy)
        );

        assign opb_o[gi]  = 8'(opb);
        assign q_o[gi]    = 8'(q);
        assign rem_o[gi]  = 4'(rem);
        assign dat_o[gi]  = d;
        assign sel_o[gi]  = s;
        assign shd_o[gi]  = shd;
        assign shdr_o[gi] = shdr;
        assign busy_o[gi] = busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Expected byte enables: the naturally aligned group of nb bytes holding lsb
    function automatic logic [3:0] model_sel(input logic [1:0] sz, input logic [1:0] l);
        int nb, base;
        logic [3:0] r;
        nb   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        base = (int'(l) / nb) * nb;
        for (int b = 0; b < 4; b++) r[b] = (b >= base) && (b < base + nb);
        return r;
    endfunction

    // Expected load result: rotate the bus word so the lane sits at bit 0, then extend
    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic [1:0] l,
                                               input logic s, input logic [31:0] d);
        logic [63:0] dd;
        logic [31:0] rot, mask;
        int bits;
        dd   = {d, d} >> (8 * int'(l));
        rot  = dd[31:0];
        bits = (sz == 2'b00) ? 8 : (sz == 2'b01) ? 16 : 32;
        if (bits == 32) return rot;
        mask = (32'd1 << bits) - 32'd1;
        if (s && rot[bits-1]) return rot | ~mask;
        return rot & mask;
    endfunction

    task automatic fill(input int u, input logic [31:0] val);
        int w, n;
        logic [7:0] ch;
        w = 1 << u;
        n = 32 / w;
        for (int s = 0; s < n; s++) begin
            ch = 8'((val >> (s * w)) & ((32'd1 << w) - 32'd1));
            op_b_sel = 1'($urandom_range(0, 1));
            if (op_b_sel) begin
                rs2 = ch;
                imm = 8'($urandom);
            end else begin
                imm = ch;
                rs2 = 8'($urandom);
            end
            init = 1'b1;
            en = '0;
            en[u] = 1'b1;
            cnt_done = (s == n - 1);
            #1;
            chk("op_b", 32'(opb_o[u]), 32'(ch));
            @(posedge clk); #1;
        end
        init = 1'b0;
        en = '0;
        cnt_done = 1'b0;
    endtask

    task automatic store_op(input int u, input logic [1:0] sz, input logic [1:0] l,
                            input logic [31:0] v);
        int nb;
        logic [31:0] ed;
        mode = 2'b01;
        size = sz;
        lsb = l;
        sgn = 1'($urandom);
        right = 1'($urandom);
        fill(u, v);
        nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        for (int b = 0; b < 4; b++) ed[8*b +: 8] = v[8*(b % nb) +: 8];
        chk("st_busy", 32'(busy_o[u]), 32'd1);
        chk("st_dat", dat_o[u], ed);
        chk("st_sel", 32'(sel_o[u]), 32'(model_sel(sz, l)));
        @(posedge clk); #1;
        chk("st_dat_hold", dat_o[u], ed);
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        chk("st_done_busy", 32'(busy_o[u]), 32'd0);
        chk("st_done_sel", 32'(sel_o[u]), 32'd0);
    endtask

    task automatic load_op(input int u, input logic [1:0] sz, input logic [1:0] l,
                           input logic s, input logic [31:0] d);
        int w, n;
        logic [31:0] got;
        w = 1 << u;
        n = 32 / w;
        mode = 2'b10;
        size = sz;
        lsb = l;
        sgn = s;
        fill(u, $urandom);
        chk("ld_busy", 32'(busy_o[u]), 32'd1);
        chk("ld_sel", 32'(sel_o[u]), 32'(model_sel(sz, l)));
        chk("ld_q_idle", 32'(q_o[u]), 32'd0);
        @(posedge clk); #1;
        dat = d;
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        dat = $urandom;
        chk("ld_drain_sel", 32'(sel_o[u]), 32'd0);
        cnt_done = 1'b1;
        init = 1'b1;
        @(posedge clk); #1;
        cnt_done = 1'b0;
        init = 1'b0;
        chk("ld_stray_done", 32'(busy_o[u]), 32'd1);
        got = '0;
        for (int k = 0; k < n; k++) begin
            got = got | (32'(q_o[u]) << (k * w));
            en = '0;
            en[u] = 1'b1;
            cnt_done = (k == n - 1);
            @(posedge clk); #1;
        end
        en = '0;
        cnt_done = 1'b0;
        chk("ld_data", got, model_load(sz, l, s, d));
        chk("ld_end_busy", 32'(busy_o[u]), 32'd0);
        chk("ld_end_q", 32'(q_o[u]), 32'd0);
    endtask

    task automatic shift_op(input int u, input logic r, input logic [4:0] sh);
        int w, n;
        logic [31:0] v;
        logic al;
        w = 1 << u;
        n = 32 / w;
        v = $urandom;
        v[4:0] = sh;
        mode = 2'b11;
        right = r;
        fill(u, v);
        al = r && (w > 1) && ((int'(sh) % w) != 0);
        chk("sh_busy", 32'(busy_o[u]), 32'd1);
        chk("sh_done_r0", 32'(shdr_o[u]), 32'd0);
        chk("sh_rem", 32'(rem_o[u]), 32'(int'(sh) % w));
        if (al) begin
            en = '0;
            en[u] = 1'b1;
            #1;
            chk("sh_align_done", 32'(shd_o[u]), 32'd0);
            @(posedge clk); #1;
            en = '0;
            chk("sh_align_rem", 32'(rem_o[u]), 32'(int'(sh) % w));
        end
        for (int s = 1; s <= n; s++) begin
            en = '0;
            en[u] = 1'b1;
            cnt_done = (s == n);
            #1;
            chk("sh_done", 32'(shd_o[u]), 32'(s * w > int'(sh)));
            @(posedge clk); #1;
            if (s < n) chk("sh_done_r", 32'(shdr_o[u]), 32'(s * w > int'(sh)));
        end
        en = '0;
        cnt_done = 1'b0;
        chk("sh_end_busy", 32'(busy_o[u]), 32'd0);
        chk("sh_end_done_r", 32'(shdr_o[u]), 32'd0);
        chk("sh_end_rem", 32'(rem_o[u]), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        en = '0;
        init = 1'b0;
        cnt_done = 1'b0;
        sgn = 1'b0;
        right = 1'b0;
        op_b_sel = 1'b0;
        ack = 1'b0;
        mode = 2'b00;
        size = 2'b00;
        lsb = 2'b00;
        rs2 = '0;
        imm = '0;
        dat = '0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int u = 0; u < 4; u++) begin
            chk("rst_busy", 32'(busy_o[u]), 32'd0);
            chk("rst_q", 32'(q_o[u]), 32'd0);
            chk("rst_dat", dat_o[u], 32'd0);
            chk("rst_sel", 32'(sel_o[u]), 32'd0);
            chk("rst_done_r", 32'(shdr_o[u]), 32'd0);
            chk("rst_rem", 32'(rem_o[u]), 32'd0);
        end

        // Ack and mode-0 init in IDLE must not start anything
        ack = 1'b1;
        init = 1'b1;
        en = 4'hf;
        mode = 2'b00;
        @(posedge clk); #1;
        ack = 1'b0;
        init = 1'b0;
        en = '0;
        for (int u = 0; u < 4; u++) chk("idle_ignore", 32'(busy_o[u]), 32'd0);

        // Directed cases
        shift_op(0, 1'b0, 5'd0);
        shift_op(2, 1'b1, 5'd13);
        store_op(1, 2'b00, 2'd2, 32'h1234_56A5);
        load_op(3, 2'b01, 2'd2, 1'b1, 32'h8001_0000);
        load_op(3, 2'b01, 2'd2, 1'b0, 32'h8001_0000);
        load_op(0, 2'b00, 2'd3, 1'b1, 32'h7F00_0000);

        // Asynchronous reset in the middle of a drain
        mode = 2'b10;
        size = 2'b10;
        lsb = 2'd0;
        sgn = 1'b0;
        fill(2, $urandom);
        dat = 32'hFFFF_FFFF;
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        for (int k = 0; k < 2; k++) begin
            en = 4'b0100;
            @(posedge clk); #1;
        end
        en = '0;
        chk("mid_drain_q", 32'(q_o[2]), 32'hF);
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy_o[2]), 32'd0);
        chk("async_rst_q", 32'(q_o[2]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        store_op(2, 2'b01, 2'd3, 32'hCAFE_BEEF);
        load_op(2, 2'b10, 2'd1, 1'b1, 32'h1234_5678);

        // Randomized operations on every width
        for (int it = 0; it < 5; it++) begin
            for (int u = 0; u < 4; u++) begin
                store_op(u, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom);
                load_op(u, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), $urandom);
                shift_op(u, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
